// File: rtl/fft_mem_pkg.sv
// Shared definitions for the FFT ping-pong stage memory: sequencer states,
// entry format codes and the lane bit-offset helper.
package fft_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic FMT_FP4 = 1'b0;
  localparam logic FMT_FP8 = 1'b1;

  // Least-significant bit position of lane k within an entry
  function automatic int lane_lo(input int k, input int lane_w);
    return k * lane_w;
  endfunction

endpackage

// File: rtl/fft_lane_bank.sv
// One bank of the ping-pong memory: lane-masked write port, format bit per
// entry, and two independent registered read ports that hold when idle.
module fft_lane_bank
  import fft_mem_pkg::*;
#(
  parameter int N          = 1024,
  parameter int DATA_W     = 16,
  parameter int LANES      = 2,
  parameter int ADDR_WIDTH = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      wr_lane_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_fmt,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic                  rd_fmt_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  output logic                  rd_fmt_b
);

  localparam int LANE_W = DATA_W / LANES;

  logic [LANES-1:0][LANE_W-1:0] mem [N];
  logic                         fmt_mem [N];

  // Storage write: each strobed lane updates its slice, any write stores the format
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_lane_en[k]) mem[wr_addr][k] <= wr_data[lane_lo(k, LANE_W) +: LANE_W];
    end
    if (|wr_lane_en) fmt_mem[wr_addr] <= wr_fmt;
  end

  // Registered read ports; output registers hold while their enable is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_a <= '0;
      rd_fmt_a  <= 1'b0;
      rd_data_b <= '0;
      rd_fmt_b  <= 1'b0;
    end else begin
      if (rd_en_a) begin
        rd_data_a <= mem[rd_addr_a];
        rd_fmt_a  <= fmt_mem[rd_addr_a];
      end
      if (rd_en_b) begin
        rd_data_b <= mem[rd_addr_b];
        rd_fmt_b  <= fmt_mem[rd_addr_b];
      end
    end
  end

endmodule

// File: rtl/fft_pingpong_mem_ctrl.sv
// Ping-pong FFT stage memory with stage sequencer. Reads come from bank
// bank_sel, writes go to the other bank; a per-lane fill bitmap gates every
// swap so a stage cannot advance on incomplete data.
module fft_pingpong_mem_ctrl
  import fft_mem_pkg::*;
#(
  parameter int N          = 1024,
  parameter int DATA_W     = 16,
  parameter int LANES      = 2,
  parameter int NUM_STAGES = $clog2(N),
  parameter int ADDR_WIDTH = $clog2(N)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              swap_req,
  input  logic                              rd_en_a,
  input  logic [ADDR_WIDTH-1:0]             rd_addr_a,
  output logic [DATA_W-1:0]                 rd_data_a,
  output logic                              rd_fmt_a,
  input  logic                              rd_en_b,
  input  logic [ADDR_WIDTH-1:0]             rd_addr_b,
  output logic [DATA_W-1:0]                 rd_data_b,
  output logic                              rd_fmt_b,
  input  logic [LANES-1:0]                  wr_lane_en,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              wr_fmt,
  output logic                              bank_sel,
  output logic [$clog2(NUM_STAGES+1)-1:0]   stage_idx,
  output logic                              busy,
  output logic                              done,
  output logic                              stage_full,
  output logic                              err_swap,
  output logic                              err_dup
);

  localparam int STAGE_W = $clog2(NUM_STAGES + 1);
  localparam int TOTAL   = N * LANES;
  localparam int FILL_W  = $clog2(TOTAL + 1);

  state_e             state;
  logic [LANES-1:0]   lane_map [N];
  logic [FILL_W-1:0]  fill_cnt;
  logic [FILL_W-1:0]  fill_add;
  logic [FILL_W-1:0]  fill_next;
  logic [LANES-1:0]   lane_old;
  logic [LANES-1:0]   new_bits;
  logic [STAGE_W-1:0] stage_next;
  logic               wr_ok, dup_hit, start_ok, swap_ok, swap_bad;
  logic               rsel_a, rsel_b;
  logic [LANES-1:0]   wr_lane0, wr_lane1;
  logic [DATA_W-1:0]  b0_data_a, b0_data_b, b1_data_a, b1_data_b;
  logic               b0_fmt_a, b0_fmt_b, b1_fmt_a, b1_fmt_b;

  // Write qualification, duplicate detection, fill accounting and swap decisions
  always_comb begin
    lane_old = lane_map[wr_addr];
    wr_ok    = (state != ST_DONE) && (|wr_lane_en);
    new_bits = wr_ok ? (wr_lane_en & ~lane_old) : '0;
    dup_hit  = wr_ok && (|(wr_lane_en & lane_old));
    fill_add = '0;
    for (int k = 0; k < LANES; k++) fill_add = fill_add + FILL_W'(new_bits[k]);
    start_ok   = start && (state != ST_RUN) && stage_full;
    swap_ok    = swap_req && (state == ST_RUN) && stage_full;
    swap_bad   = (start && !start_ok) || (swap_req && !swap_ok);
    stage_next = stage_idx + 1'b1;
    // A swap clears the stage, so a write in the swap cycle is not counted
    fill_next  = (start_ok || swap_ok) ? '0 : fill_cnt + fill_add;
  end

  // Stage sequencer: IDLE -> RUN -> DONE with registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bank_sel  <= 1'b1;
      stage_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_swap  <= 1'b0;
    end else begin
      err_swap <= swap_bad;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state     <= ST_RUN;
            bank_sel  <= ~bank_sel;
            stage_idx <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (swap_ok) begin
            bank_sel  <= ~bank_sel;
            stage_idx <= stage_next;
            if (stage_next == STAGE_W'(NUM_STAGES)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lane bitmap, fill counter and registered full / duplicate flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) lane_map[i] <= '0;
      fill_cnt   <= '0;
      stage_full <= 1'b0;
      err_dup    <= 1'b0;
    end else begin
      if (start_ok || swap_ok) begin
        for (int i = 0; i < N; i++) lane_map[i] <= '0;
      end else if (wr_ok) begin
        lane_map[wr_addr] <= lane_old | wr_lane_en;
      end
      fill_cnt   <= fill_next;
      stage_full <= (fill_next == FILL_W'(TOTAL));
      err_dup    <= dup_hit;
    end
  end

  // Remember which bank each port read from so the output mux holds with the data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsel_a <= 1'b0;
      rsel_b <= 1'b0;
    end else begin
      if (rd_en_a) rsel_a <= bank_sel;
      if (rd_en_b) rsel_b <= bank_sel;
    end
  end

  assign wr_lane0 = (wr_ok && bank_sel)  ? wr_lane_en : '0;
  assign wr_lane1 = (wr_ok && !bank_sel) ? wr_lane_en : '0;

  fft_lane_bank #(.N(N), .DATA_W(DATA_W), .LANES(LANES), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
    .clk(clk), .rst(rst),
    .wr_lane_en(wr_lane0), .wr_addr(wr_addr), .wr_data(wr_data), .wr_fmt(wr_fmt),
    .rd_en_a(rd_en_a && !bank_sel), .rd_addr_a(rd_addr_a), .rd_data_a(b0_data_a), .rd_fmt_a(b0_fmt_a),
    .rd_en_b(rd_en_b && !bank_sel), .rd_addr_b(rd_addr_b), .rd_data_b(b0_data_b), .rd_fmt_b(b0_fmt_b)
  );

  fft_lane_bank #(.N(N), .DATA_W(DATA_W), .LANES(LANES), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
    .clk(clk), .rst(rst),
    .wr_lane_en(wr_lane1), .wr_addr(wr_addr), .wr_data(wr_data), .wr_fmt(wr_fmt),
    .rd_en_a(rd_en_a && bank_sel), .rd_addr_a(rd_addr_a), .rd_data_a(b1_data_a), .rd_fmt_a(b1_fmt_a),
    .rd_en_b(rd_en_b && bank_sel), .rd_addr_b(rd_addr_b), .rd_data_b(b1_data_b), .rd_fmt_b(b1_fmt_b)
  );

  assign rd_data_a = rsel_a ? b1_data_a : b0_data_a;
  assign rd_fmt_a  = rsel_a ? b1_fmt_a  : b0_fmt_a;
  assign rd_data_b = rsel_b ? b1_data_b : b0_data_b;
  assign rd_fmt_b  = rsel_b ? b1_fmt_b  : b0_fmt_b;

endmodule

// File: tb/tb_fft_pingpong_mem_ctrl.sv
// Directed bench for fft_pingpong_mem_ctrl with N=8, LANES=2, three stages.
module tb_fft_pingpong_mem_ctrl;
  import fft_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, swap_req = 1'b0;
  logic        rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic [2:0]  rd_addr_a = '0, rd_addr_b = '0;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_fmt_a, rd_fmt_b;
  logic [1:0]  wr_lane_en = '0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_fmt = 1'b0;
  logic        bank_sel, busy, done, stage_full, err_swap, err_dup;
  logic [1:0]  stage_idx;

  int total = 0;
  int bad   = 0;

  fft_pingpong_mem_ctrl #(.N(8), .DATA_W(16), .LANES(2), .NUM_STAGES(3), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .swap_req(swap_req),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_fmt_a(rd_fmt_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_fmt_b(rd_fmt_b),
    .wr_lane_en(wr_lane_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_fmt(wr_fmt),
    .bank_sel(bank_sel), .stage_idx(stage_idx), .busy(busy), .done(done),
    .stage_full(stage_full), .err_swap(err_swap), .err_dup(err_dup)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [1:0] m, input logic [15:0] d, input logic f);
    wr_addr    = a[2:0];
    wr_lane_en = m;
    wr_data    = d;
    wr_fmt     = f;
    step();
    wr_lane_en = '0;
  endtask

  task automatic fill_all(input logic [15:0] base);
    for (int a = 0; a < 8; a++) wr(a, 2'b11, 16'(base + a), FMT_FP8);
  endtask

  task automatic rd(input int a, input int b);
    rd_addr_a = a[2:0];
    rd_addr_b = b[2:0];
    rd_en_a   = 1'b1;
    rd_en_b   = 1'b1;
    step();
    rd_en_a   = 1'b0;
    rd_en_b   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  initial begin
    // Power-on reset
    repeat (3) step();
    check("rst_bank_sel", bank_sel, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stage_idx", stage_idx, 0);
    check("rst_stage_full", stage_full, 0);
    check("rst_rd_data_a", rd_data_a, 0);
    rst = 1'b1;
    step();

    // Incomplete input bank: start rejected
    for (int a = 0; a < 7; a++) wr(a, 2'b11, 16'(16'h1100 + a), FMT_FP8);
    step();
    check("partial_full", stage_full, 0);
    do_start();
    check("partial_err_swap", err_swap, 1);
    check("partial_busy", busy, 0);
    check("partial_bank_sel", bank_sel, 1);
    step();
    check("err_swap_clears", err_swap, 0);

    // Complete the bank, then start
    wr(7, 2'b11, 16'h1107, FMT_FP8);
    step();
    check("input_full", stage_full, 1);
    do_start();
    check("start_bank_sel", bank_sel, 0);
    check("start_busy", busy, 1);
    check("start_stage_idx", stage_idx, 0);
    check("start_full_cleared", stage_full, 0);
    check("start_err_swap", err_swap, 0);
    rd(3, 5);
    check("rd_a_3", rd_data_a, 16'h1103);
    check("rd_b_5", rd_data_b, 16'h1105);
    check("rd_fmt_a_3", rd_fmt_a, 1);

    // Swap on an empty stage is rejected
    do_swap();
    check("empty_swap_err", err_swap, 1);
    check("empty_swap_idx", stage_idx, 0);

    // Packed fp4 pair written one lane at a time, then a duplicate lane
    wr(2, 2'b01, 16'h00AB, FMT_FP4);
    wr(2, 2'b10, 16'hCD00, FMT_FP4);
    check("no_dup_yet", err_dup, 0);
    wr(2, 2'b01, 16'h00AB, FMT_FP4);
    check("dup_pulse", err_dup, 1);
    wr(0, 2'b11, 16'h2200, FMT_FP8);
    check("dup_clears", err_dup, 0);
    wr(1, 2'b11, 16'h2201, FMT_FP8);
    for (int a = 3; a < 7; a++) wr(a, 2'b11, 16'(16'h2200 + a), FMT_FP8);
    wr(7, 2'b01, 16'h2207, FMT_FP8);
    step();
    check("dup_not_counted", stage_full, 0);
    wr(7, 2'b10, 16'h2207, FMT_FP8);
    step();
    check("stage1_full", stage_full, 1);

    // Swap and write in the same cycle: write lands in the pre-swap bank
    wr_addr = 3'd4; wr_lane_en = 2'b11; wr_data = 16'h5A5A; wr_fmt = FMT_FP8;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0; wr_lane_en = '0;
    check("swap1_bank_sel", bank_sel, 1);
    check("swap1_stage_idx", stage_idx, 1);
    check("swap1_full_cleared", stage_full, 0);
    rd(2, 4);
    check("packed_entry", rd_data_a, 16'hCDAB);
    check("packed_fmt", rd_fmt_a, FMT_FP4);
    check("swap_cycle_write", rd_data_b, 16'h5A5A);
    check("swap_cycle_fmt", rd_fmt_b, FMT_FP8);
    rd(7, 7);
    check("split_lanes_a", rd_data_a, 16'h2207);
    check("same_addr_b", rd_data_b, 16'h2207);

    // New stage needs all entries, including the one written in the swap cycle
    for (int a = 0; a < 8; a++) if (a != 4) wr(a, 2'b11, 16'(16'h3300 + a), FMT_FP8);
    step();
    check("swap_write_not_counted", stage_full, 0);
    wr(4, 2'b11, 16'h3304, FMT_FP8);
    check("new_stage_no_dup", err_dup, 0);
    step();
    check("stage2_full", stage_full, 1);
    do_swap();
    check("swap2_stage_idx", stage_idx, 2);
    check("swap2_bank_sel", bank_sel, 0);
    rd(6, 4);
    check("stage2_rd_a", rd_data_a, 16'h3306);
    check("stage2_rd_b", rd_data_b, 16'h3304);
    rd_addr_a = 3'd0;
    step();
    check("read_hold", rd_data_a, 16'h3306);

    // Final stage into DONE
    fill_all(16'h4400);
    step();
    do_swap();
    check("final_stage_idx", stage_idx, 3);
    check("final_done", done, 1);
    check("final_busy", busy, 0);
    check("final_bank_sel", bank_sel, 1);
    rd(1, 7);
    check("result_a", rd_data_a, 16'h4401);
    check("result_b", rd_data_b, 16'h4407);

    // Writes ignored in DONE; start and swap rejected
    fill_all(16'hFF00);
    wr(1, 2'b11, 16'hFFFF, FMT_FP4);
    check("done_no_dup", err_dup, 0);
    step();
    check("done_writes_ignored", stage_full, 0);
    rd(1, 1);
    check("done_result_kept", rd_data_a, 16'h4401);
    do_start();
    check("done_start_err", err_swap, 1);
    check("done_stays", done, 1);
    do_swap();
    check("done_swap_err", err_swap, 1);
    check("done_idx_kept", stage_idx, 3);

    // Fresh transform, then reset in the middle of RUN
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    do_swap();
    check("idle_swap_err", err_swap, 1);
    fill_all(16'h6600);
    step();
    do_start();
    check("restart_busy", busy, 1);
    fill_all(16'h7700);
    step();
    check("run_full", stage_full, 1);
    do_start();
    check("run_start_err", err_swap, 1);
    rst = 1'b0;
    #2;
    check("midrun_bank_sel", bank_sel, 1);
    check("midrun_busy", busy, 0);
    check("midrun_stage_idx", stage_idx, 0);
    check("midrun_stage_full", stage_full, 0);
    check("midrun_err_swap", err_swap, 0);
    check("midrun_err_dup", err_dup, 0);
    step();
    rst = 1'b1;
    step();
    check("post_reset_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
